// File: rtl/video_overlay_mixer.sv
// Pixel mixer: composites a movable picture window and a programmable text window over a
// solid background, with a fixed 3-cycle latency on pixels and syncs.
module video_overlay_mixer #(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned X_BITS      = 12,
    parameter int unsigned Y_BITS      = 12,
    parameter int unsigned PIC_W       = 256,
    parameter int unsigned PIC_H       = 256,
    parameter int unsigned PIC_ABITS   = 16,
    parameter int unsigned TXT_COLS    = 20,
    parameter int unsigned TXT_ROWS    = 2
) (
    input  logic                                 pix_clk,
    input  logic                                 rstn,
    input  logic [X_BITS-1:0]                    act_x,
    input  logic [Y_BITS-1:0]                    act_y,
    input  logic                                 vs_in,
    input  logic                                 hs_in,
    input  logic                                 de_in,
    input  logic [X_BITS-1:0]                    pic_x,
    input  logic [Y_BITS-1:0]                    pic_y,
    input  logic [X_BITS-1:0]                    txt_x,
    input  logic [Y_BITS-1:0]                    txt_y,
    input  logic                                 pic_en,
    input  logic                                 txt_en,
    input  logic                                 blend_en,
    input  logic                                 txt_scale,
    input  logic [3*COLOR_DEPTH-1:0]             fg_color,
    input  logic [3*COLOR_DEPTH-1:0]             bg_color,
    input  logic                                 cbuf_we,
    input  logic [$clog2(TXT_COLS*TXT_ROWS)-1:0] cbuf_addr,
    input  logic [7:0]                           cbuf_data,
    output logic [PIC_ABITS-1:0]                 pic_addr,
    input  logic [3*COLOR_DEPTH-1:0]             pic_data,
    output logic [11:0]                          font_addr,
    input  logic [7:0]                           font_data,
    output logic                                 vs_out,
    output logic                                 hs_out,
    output logic                                 de_out,
    output logic [3*COLOR_DEPTH-1:0]             pixel_data
);

    localparam int unsigned PixW     = 3 * COLOR_DEPTH;
    localparam int unsigned NumChars = TXT_COLS * TXT_ROWS;
    localparam int unsigned PicSh    = $clog2(PIC_W);

    localparam logic [X_BITS:0] PicWx  = (X_BITS+1)'(PIC_W);
    localparam logic [Y_BITS:0] PicHy  = (Y_BITS+1)'(PIC_H);
    localparam logic [X_BITS:0] TxtW1x = (X_BITS+1)'(TXT_COLS * 8);
    localparam logic [X_BITS:0] TxtW2x = (X_BITS+1)'(TXT_COLS * 16);
    localparam logic [Y_BITS:0] TxtH1y = (Y_BITS+1)'(TXT_ROWS * 16);
    localparam logic [Y_BITS:0] TxtH2y = (Y_BITS+1)'(TXT_ROWS * 32);

    // Frame-latched configuration
    logic              vs_prev_q, vs_prev_d;
    logic [X_BITS-1:0] pic_x_q, pic_x_d, txt_x_q, txt_x_d;
    logic [Y_BITS-1:0] pic_y_q, pic_y_d, txt_y_q, txt_y_d;
    logic              pic_en_q, pic_en_d, txt_en_q, txt_en_d;
    logic              blend_en_q, blend_en_d, txt_scale_q, txt_scale_d;

    logic [7:0] cbuf_q [NumChars];
    logic [7:0] cbuf_d [NumChars];

    // Window decode
    logic [X_BITS:0]       x_e, pic_x_e, txt_x_e, txt_w;
    logic [Y_BITS:0]       y_e, pic_y_e, txt_y_e, txt_h;
    logic                  pic_hit, txt_hit;
    logic [X_BITS-1:0]     dx_p, dx_t_raw, dx_t;
    logic [Y_BITS-1:0]     dy_p, dy_t_raw, dy_t;
    logic [31:0]           txt_idx;
    logic [7:0]            code_d;
    logic [PIC_ABITS-1:0]  pic_addr_d;

    // Pipeline stages
    logic                  pic_hit1_q, txt_hit1_q, pic_hit2_q, txt_hit2_q;
    logic [2:0]            bit1_q, bit2_q;
    logic [7:0]            code1_q;
    logic [3:0]            grow1_q;
    logic [PIC_ABITS-1:0]  pic_addr_q;
    logic [2:0]            sync1_q, sync2_q, sync3_q;
    logic [PixW-1:0]       pixel_q, pixel_d, blend;
    logic [COLOR_DEPTH:0]  blend_sum;
    logic                  glyph_on;

    always_comb begin
        vs_prev_d   = vs_in;
        pic_x_d     = pic_x_q;
        pic_y_d     = pic_y_q;
        txt_x_d     = txt_x_q;
        txt_y_d     = txt_y_q;
        pic_en_d    = pic_en_q;
        txt_en_d    = txt_en_q;
        blend_en_d  = blend_en_q;
        txt_scale_d = txt_scale_q;
        if (vs_in && !vs_prev_q) begin
            pic_x_d     = pic_x;
            pic_y_d     = pic_y;
            txt_x_d     = txt_x;
            txt_y_d     = txt_y;
            pic_en_d    = pic_en;
            txt_en_d    = txt_en;
            blend_en_d  = blend_en;
            txt_scale_d = txt_scale;
        end
    end

    always_comb begin
        cbuf_d = cbuf_q;
        if (cbuf_we && (32'(cbuf_addr) < NumChars)) begin
            cbuf_d[cbuf_addr] = cbuf_data;
        end
    end

    // One extra bit on every bound so windows past the screen edge clip instead of wrapping
    assign x_e     = {1'b0, act_x};
    assign y_e     = {1'b0, act_y};
    assign pic_x_e = {1'b0, pic_x_q};
    assign pic_y_e = {1'b0, pic_y_q};
    assign txt_x_e = {1'b0, txt_x_q};
    assign txt_y_e = {1'b0, txt_y_q};
    assign txt_w   = txt_scale_q ? TxtW2x : TxtW1x;
    assign txt_h   = txt_scale_q ? TxtH2y : TxtH1y;

    assign pic_hit = pic_en_q && (x_e >= pic_x_e) && (x_e < pic_x_e + PicWx) &&
                     (y_e >= pic_y_e) && (y_e < pic_y_e + PicHy);
    assign txt_hit = txt_en_q && (x_e >= txt_x_e) && (x_e < txt_x_e + txt_w) &&
                     (y_e >= txt_y_e) && (y_e < txt_y_e + txt_h);

    assign dx_p     = act_x - pic_x_q;
    assign dy_p     = act_y - pic_y_q;
    assign dx_t_raw = act_x - txt_x_q;
    assign dy_t_raw = act_y - txt_y_q;
    assign dx_t     = txt_scale_q ? (dx_t_raw >> 1) : dx_t_raw;
    assign dy_t     = txt_scale_q ? (dy_t_raw >> 1) : dy_t_raw;

    assign txt_idx    = 32'(dy_t[Y_BITS-1:4]) * TXT_COLS + 32'(dx_t[X_BITS-1:3]);
    assign code_d     = (txt_hit && (txt_idx < NumChars)) ?
                        cbuf_q[txt_idx[$clog2(NumChars)-1:0]] : 8'h00;
    assign pic_addr_d = pic_hit ? ((PIC_ABITS'(dy_p) << PicSh) + PIC_ABITS'(dx_p)) : '0;

    assign glyph_on = font_data[3'd7 - bit2_q];

    always_comb begin
        blend     = '0;
        blend_sum = '0;
        for (int c = 0; c < 3; c++) begin
            blend_sum = {1'b0, fg_color[c*COLOR_DEPTH +: COLOR_DEPTH]} +
                        {1'b0, pic_data[c*COLOR_DEPTH +: COLOR_DEPTH]};
            blend[c*COLOR_DEPTH +: COLOR_DEPTH] = blend_sum[COLOR_DEPTH:1];
        end
    end

    always_comb begin
        pixel_d = bg_color;
        if (!sync2_q[0]) begin
            pixel_d = '0;
        end else if (txt_hit2_q && glyph_on) begin
            pixel_d = (blend_en_q && pic_hit2_q) ? blend : fg_color;
        end else if (pic_hit2_q) begin
            pixel_d = pic_data;
        end
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            vs_prev_q   <= 1'b0;
            pic_x_q     <= '0;
            pic_y_q     <= '0;
            txt_x_q     <= '0;
            txt_y_q     <= '0;
            pic_en_q    <= 1'b0;
            txt_en_q    <= 1'b0;
            blend_en_q  <= 1'b0;
            txt_scale_q <= 1'b0;
            for (int unsigned i = 0; i < NumChars; i++) begin
                cbuf_q[i] <= 8'h20;
            end
            pic_hit1_q  <= 1'b0;
            txt_hit1_q  <= 1'b0;
            bit1_q      <= '0;
            code1_q     <= '0;
            grow1_q     <= '0;
            pic_addr_q  <= '0;
            pic_hit2_q  <= 1'b0;
            txt_hit2_q  <= 1'b0;
            bit2_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            pixel_q     <= '0;
        end else begin
            vs_prev_q   <= vs_prev_d;
            pic_x_q     <= pic_x_d;
            pic_y_q     <= pic_y_d;
            txt_x_q     <= txt_x_d;
            txt_y_q     <= txt_y_d;
            pic_en_q    <= pic_en_d;
            txt_en_q    <= txt_en_d;
            blend_en_q  <= blend_en_d;
            txt_scale_q <= txt_scale_d;
            cbuf_q      <= cbuf_d;
            pic_hit1_q  <= pic_hit;
            txt_hit1_q  <= txt_hit;
            bit1_q      <= dx_t[2:0];
            code1_q     <= code_d;
            grow1_q     <= dy_t[3:0];
            pic_addr_q  <= pic_addr_d;
            pic_hit2_q  <= pic_hit1_q;
            txt_hit2_q  <= txt_hit1_q;
            bit2_q      <= bit1_q;
            sync1_q     <= {vs_in, hs_in, de_in};
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            pixel_q     <= pixel_d;
        end
    end

    assign pic_addr   = pic_addr_q;
    assign font_addr  = {code1_q, grow1_q};
    assign pixel_data = pixel_q;
    assign vs_out     = sync3_q[2];
    assign hs_out     = sync3_q[1];
    assign de_out     = sync3_q[0];

endmodule

// File: doc/video_overlay_mixer.md
Name: video_overlay_mixer

Overview:
- Video pixel mixer for the HDMI display path. Composites a movable picture window (external picture ROM) and a runtime-writable text window (external 8x16 font ROM, internal character buffer) over a solid background colour.
- Successor of the fixed single-picture/fixed-string display block. Adds parametrised picture size, frame-latched runtime positions, a programmable character string, 1x/2x text scale and optional 50% text blending.
- Sits between the timing generator (act_x/act_y, syncs) and the HDMI encoder.

Parameters:
- COLOR_DEPTH, 8, bits per colour channel; pixel is 3*COLOR_DEPTH bits.
- X_BITS, 12, width of act_x and X positions.
- Y_BITS, 12, width of act_y and Y positions.
- PIC_W, 256, picture width in pixels; must be a power of 2.
- PIC_H, 256, picture height in pixels.
- PIC_ABITS, 16, picture ROM address width; must be >= log2(PIC_W*PIC_H).
- TXT_COLS, 20, characters per text row.
- TXT_ROWS, 2, text rows.

Ports:
- pix_clk  in  1  pixel clock; all logic is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- act_x  in  X_BITS  active-area X coordinate.
- act_y  in  Y_BITS  active-area Y coordinate.
- vs_in, hs_in, de_in  in  1 each  syncs (active high) and data enable.
- pic_x, txt_x  in  X_BITS each  window top-left X.
- pic_y, txt_y  in  Y_BITS each  window top-left Y.
- pic_en, txt_en, blend_en, txt_scale  in  1 each  enables; txt_scale 0 = 1x, 1 = 2x.
- fg_color, bg_color  in  3*COLOR_DEPTH each  text foreground colour, screen background colour.
- cbuf_we  in  1  character buffer write strobe.
- cbuf_addr  in  clog2(TXT_COLS*TXT_ROWS)  write index = row*TXT_COLS + col.
- cbuf_data  in  8  character code to write.
- pic_addr  out  PIC_ABITS  picture ROM address; ROM read latency is 1 cycle.
- pic_data  in  3*COLOR_DEPTH  picture ROM data.
- font_addr  out  12  {code[7:0], glyph_row[3:0]}; ROM read latency is 1 cycle.
- font_data  in  8  glyph row; bit 7 is the leftmost pixel.
- vs_out, hs_out, de_out  out  1 each  syncs and data enable delayed by 3 cycles.
- pixel_data  out  3*COLOR_DEPTH  mixed pixel.

Behaviour:

Reset:
- vs_out, hs_out, de_out, pixel_data, pic_addr and all pipeline registers reset to 0.
- Shadow configuration registers reset to 0, so both windows are disabled.
- All character buffer entries reset to 8'h20.

Shadow configuration:
- pic_x/y, txt_x/y, txt_scale and the three enables are copied into shadow registers only on the cycle where vs_in=1 and the registered previous vs_in=0 (vs_in rising edge).
- fg_color and bg_color are used live, not shadowed.

Window tests (computed on act_x/act_y and shadow values):
- Comparisons are done in X_BITS+1 / Y_BITS+1 bits, so a window that extends past H_ACT/V_ACT is clipped without wrap-around.
- Picture window: pic_x <= x < pic_x+PIC_W and pic_y <= y < pic_y+PIC_H.
- Text window: txt_x <= x < txt_x+TXT_COLS*8*s and txt_y <= y < txt_y+TXT_ROWS*16*s, where s = 1 or 2.
- dx/dy are the offsets from the text window origin. When s=2 they are halved (>>1) before col=dx/8, bit=dx%8, row=dy/16, glyph_row=dy%16.

Pipeline (fixed latency of 3 pix_clk cycles for every output):
- E1: register the window flags, bit index and de. Register pic_addr = ((y-pic_y) << log2(PIC_W)) + (x-pic_x) when inside the picture window, else 0. Register code = cbuf[row*TXT_COLS+col]. font_addr is driven combinationally from the E1 code and glyph_row.
- E2: the ROMs return pic_data and font_data. Register the E1 flags and bit index forward.
- E3: register pixel_data, selected in this priority order:
  1. de=0 gives 0.
  2. Text window with font_data[7-bit]=1 gives fg_color. If blend_en=1 and the pixel is also in the picture window, it gives the per-channel (fg+pic)>>1 instead, computed at COLOR_DEPTH+1 bits with truncation.
  3. Picture window gives pic_data.
  4. Otherwise bg_color.
- A window whose enable is 0 is treated as not hit. Text-window pixels whose glyph bit is 0 are transparent.
- vs/hs/de pass through 3 register stages.

Character buffer:
- Write takes effect at the clock edge.
- A same-cycle read of the address being written returns the old value.
- Writes with cbuf_addr >= TXT_COLS*TXT_ROWS are ignored.

Reset mid-frame:
- Outputs go to 0 immediately and the shadows clear.
- Output is background-only until the next vs_in rising edge after rstn is released.

Test Plan:
1. Reset, then run one frame with default inputs and pic_en=0, txt_en=0 -> pixel_data=bg_color whenever de_out=1 and 0 whenever de_out=0. Syncs lag their inputs by exactly 3 cycles.
2. pic_en=1, pic_x=512, pic_y=232, with a ROM model whose data equals its address -> at x=512, y=232 pic_addr=0. At x=767, y=487 pic_addr=65535. Three cycles after each, pixel_data is the matching ROM data; x=511 and x=768 give bg_color.
3. Write 8'h41 to cbuf index 0, txt_en=1, txt_x=100, txt_y=50, scale 1x -> font_addr=12'h410 at (100,50). Glyph bit 1 gives fg_color 3 cycles later; bit 0 gives bg_color. With scale 2x, pixels 100 and 101 are identical.
4. Text window overlapping the picture, fg=24'hFF0000, pic_data=24'h00FF00, blend_en=1 -> fg pixel = 24'h7F7F00. With blend_en=0 -> 24'hFF0000.
5. Change pic_x from 512 to 600 mid-frame -> no change until the vs_in rising edge; the next frame starts at x=600.
6. txt_x=1270 with 20 columns -> text is clipped at x=1279 with no wrap-around to x=0. Write to index 40 (out of range) -> buffer is unchanged. Assert rstn mid-line -> all outputs are 0 immediately.
